// File: rtl/servo_pwm_bank.sv
// servo_pwm_bank
//   CH_NUM servo PWM outputs driven from one shared frame counter. Period and
//   widths are double buffered: requested values are copied into shadow
//   registers only at the frame boundary, so a frame is never torn by an
//   update. An optional watchdog forces every channel to a safe width when
//   updates stop arriving.
//
//   Build option: define SERVO_FAILSAFE_EN to build the watchdog/failsafe
//   logic. Without it failsafe_active is tied low and the last loaded widths
//   are held indefinitely.
//
//   Update handshake: data_update_flag is a valid-only, 1-cycle pulse with no
//   ready/backpressure. It marks pulse_period/pulse_width as a complete new
//   set; the block never stalls the producer and samples the pulse_* inputs
//   only at the next frame boundary (or at the same cycle if the pulse lands
//   on the boundary tick).
module servo_pwm_bank #(
  parameter int CH_NUM         = 8,
  parameter int CNT_W          = 15,
  parameter int DEFAULT_PERIOD = 20000,
  parameter int TICKS_PER_MS   = 1000,
  parameter int DOG_TIMEOUT_MS = 70,
  parameter int FAILSAFE_WIDTH = 1500
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    pwm_clk,
  input  logic [CNT_W-1:0]        pulse_period,
  input  logic [CH_NUM*CNT_W-1:0] pulse_width,
  input  logic                    data_update_flag,
  output logic [CH_NUM-1:0]       pwm_out,
  output logic                    frame_start,
  output logic                    failsafe_active
);

  localparam logic [CNT_W-1:0] DEF_PERIOD = CNT_W'(DEFAULT_PERIOD);
  // Periods below 2 would make the boundary compare degenerate; they are refused.
  localparam logic [CNT_W-1:0] MIN_PERIOD = CNT_W'(2);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] period_sh;
  logic [CNT_W-1:0] width_sh [CH_NUM];
  logic             upd_pending;
  logic             boundary;
  logic             load;
  logic             fs_sel;
  logic             fs_changed;

  // The boundary is the tick that takes cnt from period_sh-1 back to 0.
  assign boundary = pwm_clk && (cnt == period_sh - 1'b1);
  // Shadows reload only at a boundary, and only if something asked for it.
  assign load     = boundary && (upd_pending || data_update_flag || fs_changed);

  // Shared frame counter: 0 .. period_sh-1, advancing on pwm_clk ticks.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (pwm_clk) begin
      cnt <= boundary ? '0 : cnt + 1'b1;
    end
  end

  // Shadow registers: copy requested (or failsafe) values at the boundary.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      period_sh <= DEF_PERIOD;
      for (int i = 0; i < CH_NUM; i++) width_sh[i] <= '0;
    end else if (load) begin
      if (fs_sel) begin
        // Failsafe replaces widths only; the frame rate keeps running as is.
        for (int i = 0; i < CH_NUM; i++) width_sh[i] <= fs_width_value();
      end else begin
        for (int i = 0; i < CH_NUM; i++) width_sh[i] <= pulse_width[i*CNT_W +: CNT_W];
        if (pulse_period >= MIN_PERIOD) period_sh <= pulse_period;
      end
    end
  end

  // Remember a request made mid-frame until the boundary consumes it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      upd_pending <= 1'b0;
    end else if (load) begin
      upd_pending <= 1'b0;
    end else if (data_update_flag && !boundary) begin
      upd_pending <= 1'b1;
    end
  end

  // Registered compare and frame marker; both lag cnt by one clk.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwm_out     <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= boundary;
      for (int i = 0; i < CH_NUM; i++) pwm_out[i] <= (cnt < width_sh[i]);
    end
  end

`ifdef SERVO_FAILSAFE_EN
  localparam int               MS_W     = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam int               DOG_W    = $clog2(DOG_TIMEOUT_MS + 1);
  localparam logic [MS_W-1:0]  MS_LAST  = MS_W'(TICKS_PER_MS - 1);
  localparam logic [DOG_W-1:0] DOG_MAX  = DOG_W'(DOG_TIMEOUT_MS);
  localparam logic [CNT_W-1:0] FS_WIDTH = CNT_W'(FAILSAFE_WIDTH);

  logic [MS_W-1:0]  ms_cnt;
  logic [DOG_W-1:0] dog_cnt;
  logic             fs_loaded;

  function automatic logic [CNT_W-1:0] fs_width_value();
    return FS_WIDTH;
  endfunction

  // Millisecond prescaler and saturating watchdog; any update restarts both.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ms_cnt  <= '0;
      dog_cnt <= '0;
    end else if (data_update_flag) begin
      ms_cnt  <= '0;
      dog_cnt <= '0;
    end else if (pwm_clk) begin
      if (ms_cnt == MS_LAST) begin
        ms_cnt <= '0;
        if (dog_cnt != DOG_MAX) dog_cnt <= dog_cnt + 1'b1;
      end else begin
        ms_cnt <= ms_cnt + 1'b1;
      end
    end
  end

  // Failsafe flag; an update in the same cycle as the timeout wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      failsafe_active <= 1'b0;
    end else if (data_update_flag) begin
      failsafe_active <= 1'b0;
    end else if (dog_cnt == DOG_MAX) begin
      failsafe_active <= 1'b1;
    end
  end

  // Failsafe state captured at the last load, so entry/exit forces a reload.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fs_loaded <= 1'b0;
    end else if (load) begin
      fs_loaded <= failsafe_active;
    end
  end

  assign fs_sel     = failsafe_active;
  assign fs_changed = (failsafe_active != fs_loaded);
`else
  function automatic logic [CNT_W-1:0] fs_width_value();
    return '0;
  endfunction

  assign failsafe_active = 1'b0;
  assign fs_sel          = 1'b0;
  assign fs_changed      = 1'b0;
`endif

endmodule

// File: tb/tb_servo_pwm_bank.sv
// tb_servo_pwm_bank
//   Directed sequence with randomised tick spacing and values. A frame-level
//   reference model predicts frame boundaries, per-clk outputs and per-frame
//   high-tick counts; the bench is built with small timing parameters so a
//   frame is 200 ticks and the watchdog fires after 70 "ms" of 10 ticks.
module tb_servo_pwm_bank;

  localparam int CH_NUM     = 4;
  localparam int CNT_W      = 12;
  localparam int DEF_PERIOD = 200;
  localparam int TPM        = 10;
  localparam int DOG_MS     = 70;
  localparam int FS_WIDTH   = 15;

  // clock / reset and DUT signals
  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    pwm_clk;
  logic                    data_update_flag;
  logic [CNT_W-1:0]        pulse_period;
  logic [CH_NUM*CNT_W-1:0] pulse_width;
  logic [CH_NUM-1:0]       pwm_out;
  logic                    frame_start;
  logic                    failsafe_active;

  int total = 0;
  int bad   = 0;

  // scoreboard: expected high ticks per channel for each frame in flight
  logic [CNT_W-1:0] exp_q[$];

  // reference model state
  int pos;                 // ticks elapsed in the current frame
  int cur_period;
  int cur_w    [CH_NUM];
  int acc_high [CH_NUM];
  int frames;
  bit req;                 // an update is waiting for the next boundary
  bit fs_m;                // model of failsafe_active
  bit fs_loaded;           // failsafe state used at the last shadow load
`ifdef SERVO_FAILSAFE_EN
  localparam int DOG_TICKS = TPM * DOG_MS;
  int since;               // ticks since the last update (saturating)
`endif

  servo_pwm_bank #(
    .CH_NUM(CH_NUM), .CNT_W(CNT_W), .DEFAULT_PERIOD(DEF_PERIOD),
    .TICKS_PER_MS(TPM), .DOG_TIMEOUT_MS(DOG_MS), .FAILSAFE_WIDTH(FS_WIDTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pwm_clk(pwm_clk),
    .pulse_period(pulse_period), .pulse_width(pulse_width),
    .data_update_flag(data_update_flag), .pwm_out(pwm_out),
    .frame_start(frame_start), .failsafe_active(failsafe_active)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic push_frame();
    for (int i = 0; i < CH_NUM; i++)
      exp_q.push_back(CNT_W'((cur_w[i] < cur_period) ? cur_w[i] : cur_period));
  endtask

  task automatic model_reset();
    pos = 0; cur_period = DEF_PERIOD; req = 0; fs_m = 0; fs_loaded = 0;
    for (int i = 0; i < CH_NUM; i++) begin cur_w[i] = 0; acc_high[i] = 0; end
`ifdef SERVO_FAILSAFE_EN
    since = 0;
`endif
    exp_q.delete();
    push_frame();
  endtask

  initial begin : monitor
    logic                    rst_e, tick_e, flag_e;
    logic [CNT_W-1:0]        pp_e;
    logic [CH_NUM*CNT_W-1:0] pw_e;
    logic [CH_NUM-1:0]       exp_out;
    bit                      bnd, fs_pre;
    frames = 0;
    model_reset();
    forever begin
      @(posedge clk);
      rst_e  = !rst_n;
      tick_e = pwm_clk && rst_n;
      flag_e = data_update_flag && rst_n;
      pp_e   = pulse_period;
      pw_e   = pulse_width;
      #1;
      if (rst_e) begin
        model_reset();
        check("reset_pwm_out", pwm_out, 0);
        check("reset_frame_start", frame_start, 0);
      end else begin
        // output shows the frame position held before this edge
        for (int i = 0; i < CH_NUM; i++) exp_out[i] = (pos < cur_w[i]);
        check("pwm_out", pwm_out, exp_out);
        fs_pre = fs_m;
`ifdef SERVO_FAILSAFE_EN
        if (flag_e) begin
          fs_m = 0; since = 0;
        end else begin
          if (since >= DOG_TICKS) fs_m = 1;
          if (tick_e && since < DOG_TICKS) since++;
        end
`endif
        if (flag_e) req = 1;
        bnd = 0;
        if (tick_e) begin
          for (int i = 0; i < CH_NUM; i++) acc_high[i] += pwm_out[i];
          pos++;
          if (pos == cur_period) bnd = 1;
        end
        check("frame_start", frame_start, bnd);
        if (bnd) begin
          for (int i = 0; i < CH_NUM; i++) begin
            check($sformatf("frame_high_ch%0d", i), acc_high[i], exp_q.pop_front());
            acc_high[i] = 0;
          end
          pos = 0;
          frames++;
          if (req || fs_pre != fs_loaded) begin
            if (fs_pre) begin
              for (int i = 0; i < CH_NUM; i++) cur_w[i] = FS_WIDTH;
            end else begin
              for (int i = 0; i < CH_NUM; i++) cur_w[i] = pw_e[i*CNT_W +: CNT_W];
              if (pp_e >= 2) cur_period = pp_e;
            end
            fs_loaded = fs_pre;
            req = 0;
          end
          push_frame();
        end
      end
      check("failsafe_active", failsafe_active, fs_m);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input bit tick, input bit flag);
    @(negedge clk);
    pwm_clk = tick;
    data_update_flag = flag;
  endtask

  task automatic run(input int n);
    repeat (n) cyc($urandom_range(0, 2) != 0, 1'b0);
  endtask

  task automatic flag_now();
    cyc($urandom_range(0, 2) != 0, 1'b1);
  endtask

  task automatic set_w(input int ch, input int w);
    pulse_width[ch*CNT_W +: CNT_W] = CNT_W'(w);
  endtask

  task automatic wait_frames(input int n);
    int target;
    int budget;
    target = frames + n;
    budget = n * 1500;
    while (frames < target && budget > 0) begin run(1); budget--; end
    check("frame_wait_timeout", frames >= target, 1);
  endtask

  // Raise the flag exactly on the tick that closes the current frame.
  task automatic flag_at_boundary();
    bit done;
    int budget;
    done = 0;
    budget = 2000;
    while (!done && budget > 0) begin
      @(negedge clk);
      if (pos == cur_period - 1) begin
        pwm_clk = 1'b1; data_update_flag = 1'b1; done = 1;
      end else begin
        pwm_clk = ($urandom_range(0, 2) != 0); data_update_flag = 1'b0;
      end
      budget--;
    end
    check("boundary_wait_timeout", done, 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin : main
    int budget;
    rst_n = 1'b0; pwm_clk = 1'b0; data_update_flag = 1'b0;
    pulse_period = '0; pulse_width = '0;
    repeat (3) @(negedge clk);
    check("rst_pwm_out", pwm_out, 0);
    check("rst_frame_start", frame_start, 0);
    check("rst_failsafe", failsafe_active, 0);
    rst_n = 1'b1;

    // idle: default period, all outputs low
    wait_frames(2);

    // mixed widths: normal, zero, above period, random
    pulse_period = CNT_W'(200);
    set_w(0, 15); set_w(1, 0); set_w(2, 250); set_w(3, $urandom_range(1, 199));
    run(100);
    flag_now();
    run(20);
    wait_frames(2);

    // inputs changing without a flag have no effect
    for (int i = 0; i < CH_NUM; i++) set_w(i, $urandom_range(0, 220));
    pulse_period = CNT_W'($urandom_range(50, 250));
    wait_frames(1);

    // flag on the boundary tick, then a mid-frame flag one frame later
    pulse_period = CNT_W'(200);
    for (int i = 0; i < CH_NUM; i++) set_w(i, $urandom_range(20, 180));
    flag_at_boundary();
    run(60);
    for (int i = 0; i < CH_NUM; i++) set_w(i, 10);
    flag_now();
    wait_frames(3);

    // illegal periods rejected, widths still load; then a legal change
    pulse_period = CNT_W'(1);
    for (int i = 0; i < CH_NUM; i++) set_w(i, $urandom_range(0, 199));
    flag_now();
    wait_frames(2);
    pulse_period = CNT_W'(0);
    set_w(0, 77);
    flag_now();
    wait_frames(2);
    pulse_period = CNT_W'(120);
    flag_now();
    wait_frames(2);

    // random updates at random points in the frame
    for (int k = 0; k < 6; k++) begin
      pulse_period = CNT_W'($urandom_range(0, 260));
      for (int i = 0; i < CH_NUM; i++) set_w(i, $urandom_range(0, 280));
      run($urandom_range(0, 300));
      flag_now();
      wait_frames($urandom_range(1, 2));
    end

    pulse_period = CNT_W'(200);
    for (int i = 0; i < CH_NUM; i++) set_w(i, 40);
    flag_now();
    wait_frames(2);

`ifdef SERVO_FAILSAFE_EN
    // watchdog expiry, failsafe widths, then recovery by an update
    budget = 6000;
    while (!fs_m && budget > 0) begin run(1); budget--; end
    check("failsafe_entry", failsafe_active, 1);
    wait_frames(2);
    for (int i = 0; i < CH_NUM; i++) set_w(i, 12);
    flag_now();
    run(1);
    check("failsafe_exit", failsafe_active, 0);
    wait_frames(2);
`else
    // no watchdog: long silence keeps the last widths
    run(1800);
    check("no_failsafe", failsafe_active, 0);
    wait_frames(2);
`endif

    // reset in the middle of a high pulse
    for (int i = 0; i < CH_NUM; i++) set_w(i, 150);
    flag_now();
    wait_frames(2);
    run(20);
    check("pulse_high_before_reset", pwm_out[0], 1);
    @(negedge clk);
    rst_n = 1'b0;
    pwm_clk = ($urandom_range(0, 1) != 0);
    @(negedge clk);
    rst_n = 1'b1;
    check("pwm_low_after_reset", pwm_out, 0);
    check("frame_start_after_reset", frame_start, 0);
    wait_frames(2);

    check("frames_seen", frames >= 30, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
